// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the 5-stage (IF, ID, EX, MEM, WB) core.
// Contents:
//   REG_ADDR_W   - width of a register-file address
//   REG_ZERO     - hard-wired zero register; a write to it never creates a hazard
//   PIPE_STAGES  - number of pipeline stages
//   ctrl_mode_t  - the front-end control decision made each cycle
//   reg_matches  - does an in-flight destination satisfy one source operand
package hazard_stall_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int PIPE_STAGES = 5;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_STALL = 2'd1,
        MODE_FLUSH = 2'd2,
        MODE_HOLD  = 2'd3
    } ctrl_mode_t;

    // True when an in-flight destination supplies a source the ID instruction
    // actually reads. Register 0 is excluded because it always reads as zero.
    function automatic logic reg_matches(input logic [REG_ADDR_W-1:0] rd,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic                  uses);
        return uses && (rd == src) && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_inflight_tracker.sv
// In-flight destination tracker.
// A CHECK_DEPTH-entry shift register of {v, rd}: entry 0 is the instruction in
// EX, the last entry is the oldest still waiting to write back. On each shift
// the insert value enters entry 0 and the oldest entry drops out.
// Ports:
//   clock, reset          - pipeline clock, synchronous active-high reset
//   shift_en              - advance the shift register this cycle
//   insert_v, insert_rd   - value shifted into entry 0
//   id_valid              - ID holds a real instruction
//   rs, uses_rs           - source A and whether it is read
//   rt, uses_rt           - source B and whether it is read
//   hit                   - ID instruction reads a register still pending
module hazard_stall_ctrl_inflight_tracker
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CHECK_DEPTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic                  insert_v,
    input  logic [REG_ADDR_W-1:0] insert_rd,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  uses_rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  uses_rt,
    output logic                  hit
);

    logic                  entry_v_reg  [CHECK_DEPTH];
    logic [REG_ADDR_W-1:0] entry_rd_reg [CHECK_DEPTH];
    logic [CHECK_DEPTH-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < CHECK_DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_head
                always_ff @(posedge clock) begin
                    if (reset) begin
                        entry_v_reg[gi]  <= 1'b0;
                        entry_rd_reg[gi] <= REG_ZERO;
                    end else if (shift_en) begin
                        entry_v_reg[gi]  <= insert_v;
                        entry_rd_reg[gi] <= insert_rd;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clock) begin
                    if (reset) begin
                        entry_v_reg[gi]  <= 1'b0;
                        entry_rd_reg[gi] <= REG_ZERO;
                    end else if (shift_en) begin
                        entry_v_reg[gi]  <= entry_v_reg[gi-1];
                        entry_rd_reg[gi] <= entry_rd_reg[gi-1];
                    end
                end
            end

            assign match[gi] = entry_v_reg[gi] &
                               (reg_matches(entry_rd_reg[gi], rs, uses_rs) |
                                reg_matches(entry_rd_reg[gi], rt, uses_rt));
        end
    endgenerate

    assign hit = id_valid & (|match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Interlock controller for a 5-stage pipeline without forwarding.
// Stalls the front end while the ID instruction reads a register that an
// instruction in EX/MEM/WB has yet to write back, bubbles ID_EX on stalls and
// branch squashes, honours a global hold, and counts stall cycles.
// Parameters:
//   CHECK_DEPTH - in-flight stages checked (3; 2 for write-before-read RF)
//   CNT_W       - width of the saturating stall counter
// Ports:
//   clock, reset            - pipeline clock, synchronous active-high reset
//   id_valid                - ID holds a real instruction
//   id_rs/id_rt             - source registers, qualified by id_uses_rs/rt
//   id_rd, id_writes        - destination register and its write enable
//   flush                   - taken branch: squash the ID instruction
//   hold                    - external freeze of the whole pipeline
//   pc_en, if_id_en         - front-end load enables
//   id_ex_bubble            - zero the ID_EX inputs this cycle
//   pipe_en                 - advance enable for ID_EX and later stages
//   stall                   - RAW interlock active
//   stall_count             - saturating count of interlock cycles
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CHECK_DEPTH = 3,
    parameter int CNT_W       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_writes,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_bubble,
    output logic                  pipe_en,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    logic                  hit;
    logic                  shift_en;
    logic                  insert_v;
    logic [REG_ADDR_W-1:0] insert_rd;
    ctrl_mode_t            mode;
    logic [CNT_W-1:0]      stall_count_reg;
    logic [CNT_W-1:0]      stall_count_next;

    hazard_stall_ctrl_inflight_tracker #(
        .CHECK_DEPTH (CHECK_DEPTH)
    ) u_tracker (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (shift_en),
        .insert_v  (insert_v),
        .insert_rd (insert_rd),
        .id_valid  (id_valid),
        .rs        (id_rs),
        .uses_rs   (id_uses_rs),
        .rt        (id_rt),
        .uses_rt   (id_uses_rt),
        .hit       (hit)
    );

    // Priority below reset: hold, then flush, then the RAW hit.
    always_comb begin
        mode = MODE_RUN;
        if (hold)       mode = MODE_HOLD;
        else if (flush) mode = MODE_FLUSH;
        else if (hit)   mode = MODE_STALL;
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_bubble = 1'b0;
        stall        = 1'b0;
        shift_en     = 1'b1;
        insert_v     = 1'b0;
        insert_rd    = REG_ZERO;
        case (mode)
            MODE_HOLD: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                shift_en = 1'b0;
            end
            MODE_FLUSH: begin
                // Squashed instruction becomes a bubble: tracker takes {0, 0}.
                id_ex_bubble = 1'b1;
            end
            MODE_STALL: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
                stall        = 1'b1;
            end
            default: begin
                // A write to r0 is recorded as invalid so it can never match.
                insert_v  = id_valid & id_writes & (id_rd != REG_ZERO);
                insert_rd = id_rd;
            end
        endcase
    end

    assign pipe_en = ~hold;

    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall && (stall_count_reg != {CNT_W{1'b1}}))
            stall_count_next = stall_count_reg + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) stall_count_reg <= '0;
        else       stall_count_reg <= stall_count_next;
    end

    assign stall_count = stall_count_reg;

endmodule
